// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, requester
// identity, RISC-V funct3 width codes and the byte-count constants.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_MA = 1'b1
   } owner_t;

   // funct3 width codes of the load/store port
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // number of RAM bytes moved by one transaction
   localparam logic [2:0] NB_BYTE = 3'd1;
   localparam logic [2:0] NB_HALF = 3'd2;
   localparam logic [2:0] NB_WORD = 3'd4;

   // Reserved funct3 codes move a full word.
   function automatic logic [2:0] byte_count(input logic [2:0] width);
      case (width)
         F3_B, F3_BU: return NB_BYTE;
         F3_H, F3_HU: return NB_HALF;
         default:     return NB_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatting: takes the little-endian byte buffer gathered from
// RAM and sign/zero-extends it according to the funct3 width code.
module mem_load_ext
   import mem_arbiter_pkg::*;
(
   input  logic [2:0]  width,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   // Select byte/half/word and extend; reserved codes pass the full word.
   always_comb begin
      data = raw;
      case (width)
         F3_B:    data = {{24{raw[7]}}, raw[7:0]};
         F3_BU:   data = {24'h000000, raw[7:0]};
         F3_H:    data = {{16{raw[15]}}, raw[15:0]};
         F3_HU:   data = {16'h0000, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter between an instruction-fetch port (IF) and a
// load/store port (MA) sharing one 8-bit RAM with one-cycle read latency.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise MA has fixed priority over IF.
//
// Request/done handshake: a requester raises its req (if_req, ma_re/ma_we)
// with stable address/data and holds it until its done pulse; done is high
// for exactly one enabled cycle, read data is valid only in that cycle, and
// the requester drops req at the clock edge that ends the done cycle.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        ma_re,
   input  logic        ma_we,
   input  logic [2:0]  ma_width,
   input  logic [31:0] ma_addr,
   input  logic [31:0] ma_wdata,
   output logic        ma_done,
   output logic [31:0] ma_rdata,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output arb_state_t  dbg_state
);

   arb_state_t  state_q, state_d;
   owner_t      owner_q;
   logic        is_wr_q;
   logic [2:0]  width_q;
   logic [2:0]  nbytes_q;
   logic [1:0]  cnt_q;
   logic [31:0] wdata_q;
   logic [31:0] rbuf_q;
   logic [31:0] mem_a_q;
   logic [7:0]  din_hold_q;
   logic        rdy_q;

   logic        ma_req;
   logic        any_req;
   logic        grant_ma;
   logic        last_byte;
   logic [1:0]  cap_idx;
   logic [7:0]  din_cur;
   logic [31:0] ext_data;

   assign ma_req    = ma_re | ma_we;
   assign any_req   = ma_req | if_req;
   assign last_byte = (({1'b0, cnt_q} + 3'd1) == nbytes_q);
   // byte k-1 arrives during XFER cycle k; the final byte arrives in LAST
   assign cap_idx   = (state_q == LAST) ? cnt_q : (cnt_q - 2'd1);
   // after a freeze the RAM output has moved on; use the byte saved on entry
   assign din_cur   = rdy_q ? mem_din : din_hold_q;

`ifdef MEM_ARB_RR_EN
   logic prio_ma_q;

   // Round-robin pointer: the requester not served last wins a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_ma_q <= 1'b1;
      end else if (rdy && (state_q == DONE)) begin
         prio_ma_q <= (owner_q == OWN_IF);
      end
   end

   assign grant_ma = ma_req & (~if_req | prio_ma_q);
`else
   assign grant_ma = ma_req;
`endif

   // FSM state register; rdy low freezes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   // Next-state: one outstanding transaction, reads take an extra LAST cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = XFER;
         XFER:    if (last_byte) state_d = is_wr_q ? DONE : LAST;
         LAST:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction latch, byte counter, RAM address and read-byte assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= OWN_MA;
         is_wr_q  <= 1'b0;
         width_q  <= F3_W;
         nbytes_q <= NB_WORD;
         cnt_q    <= 2'd0;
         wdata_q  <= 32'h0;
         rbuf_q   <= 32'h0;
         mem_a_q  <= 32'h0;
      end else if (rdy) begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q  <= grant_ma ? OWN_MA : OWN_IF;
                  is_wr_q  <= grant_ma & ma_we;
                  width_q  <= grant_ma ? ma_width : F3_W;
                  nbytes_q <= grant_ma ? byte_count(ma_width) : NB_WORD;
                  wdata_q  <= ma_wdata;
                  mem_a_q  <= grant_ma ? ma_addr : if_addr;
                  cnt_q    <= 2'd0;
                  rbuf_q   <= 32'h0;
               end
            end
            XFER: begin
               if (cnt_q != 2'd0) begin
                  rbuf_q[{cap_idx, 3'b000} +: 8] <= din_cur;
               end
               if (!last_byte) begin
                  cnt_q   <= cnt_q + 2'd1;
                  mem_a_q <= mem_a_q + 32'd1;
               end
            end
            LAST: begin
               rbuf_q[{cap_idx, 3'b000} +: 8] <= din_cur;
            end
            default: begin
            end
         endcase
      end
   end

   // Save the RAM byte seen in the first frozen cycle so it survives the freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q      <= 1'b1;
         din_hold_q <= 8'h00;
      end else begin
         rdy_q <= rdy;
         if (!rdy && rdy_q) begin
            din_hold_q <= mem_din;
         end
      end
   end

   mem_load_ext u_load_ext (
      .width (width_q),
      .raw   (rbuf_q),
      .data  (ext_data)
   );

   assign dbg_state = state_q;
   assign if_done   = rdy && (state_q == DONE) && (owner_q == OWN_IF);
   assign ma_done   = rdy && (state_q == DONE) && (owner_q == OWN_MA);
   assign if_rdata  = ((state_q == DONE) && (owner_q == OWN_IF)) ? rbuf_q : 32'h0;
   assign ma_rdata  = ((state_q == DONE) && (owner_q == OWN_MA)) ? ext_data : 32'h0;
   assign mem_a     = mem_a_q;
   assign mem_wr    = rdy && (state_q == XFER) && is_wr_q;
   assign mem_dout  = ((state_q == XFER) && is_wr_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM model, request drivers, scoreboard of
// expected read results in request order, latency and store-byte checks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        ma_re;
   logic        ma_we;
   logic [2:0]  ma_width;
   logic [31:0] ma_addr;
   logic [31:0] ma_wdata;
   logic        ma_done;
   logic [31:0] ma_rdata;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   arb_state_t  dbg_state;

   int          total_cnt;
   int          bad_cnt;
   int          wr_cnt;
   logic        cur_st;
   logic [31:0] exp_q[$];
   bit          exp_src_q[$];
   logic [7:0]  init_ram [logic [31:0]];
   logic [7:0]  wr_ram   [logic [31:0]];

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .ma_re     (ma_re),
      .ma_we     (ma_we),
      .ma_width  (ma_width),
      .ma_addr   (ma_addr),
      .ma_wdata  (ma_wdata),
      .ma_done   (ma_done),
      .ma_rdata  (ma_rdata),
      .mem_a     (mem_a),
      .mem_wr    (mem_wr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total_cnt, bad_cnt);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (wr_ram.exists(a)) return wr_ram[a];
      if (init_ram.exists(a)) return init_ram[a];
      return 8'h00;
   endfunction

   // RAM model: write strobe at the edge, read data one cycle after address
   always @(posedge clk) begin
      if (mem_wr === 1'b1) wr_ram[mem_a] = mem_dout;
      mem_din <= mem_rd(mem_a);
   end

   // count write strobes, sampled well after the falling edge
   initial wr_cnt = 0;
   always @(negedge clk) begin
      #2;
      if (mem_wr === 1'b1) wr_cnt = wr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // reference load result from the RAM contents
   function automatic logic [31:0] exp_load(input logic [2:0] w, input logic [31:0] a);
      logic [31:0] word;
      word = {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
      case (w)
         3'b000:  return {{24{word[7]}}, word[7:0]};
         3'b100:  return {24'h000000, word[7:0]};
         3'b001:  return {{16{word[15]}}, word[15:0]};
         3'b101:  return {16'h0000, word[15:0]};
         default: return word;
      endcase
   endfunction

   task automatic preload(input logic [31:0] a, input int n);
      for (int k = 0; k < n; k++) init_ram[a + 32'(k)] = 8'($urandom_range(0, 255));
   endtask

   // driver tasks
   task automatic drv_ma(input logic we, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] d);
      ma_re = ~we; ma_we = we; ma_width = w; ma_addr = a; ma_wdata = d; cur_st = we;
      if (!we) begin
         exp_q.push_back(exp_load(w, a));
         exp_src_q.push_back(1'b1);
      end
   endtask

   task automatic drv_if(input logic [31:0] a);
      if_req = 1'b1; if_addr = a;
      exp_q.push_back(exp_load(3'b010, a));
      exp_src_q.push_back(1'b0);
   endtask

   // scoreboard pop on a done pulse
   task automatic sb_pop(input bit src, input logic [31:0] got);
      logic [31:0] e;
      bit          s;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         s = exp_src_q.pop_front();
         check_eq("sb_src", 32'(src), 32'(s));
         check_eq("sb_data", got, e);
      end
   endtask

   // wait for the expected done pulses (latency 0 = must not occur),
   // optionally dropping rdy for frz_len cycles starting in cycle frz_at
   task automatic run_wait(input int ma_lat, input int if_lat, input int frz_at, input int frz_len);
      int cyc;
      int pend;
      pend = 0;
      if (ma_lat > 0) pend++;
      if (if_lat > 0) pend++;
      cyc = 0;
      while (pend > 0 && cyc < 60) begin
         tick();
         cyc++;
         if (rdy == 1'b0) check_eq("frz_wr", 32'(mem_wr), 32'd0);
         if (ma_done === 1'b1) begin
            check_eq("ma_lat", 32'(cyc), 32'(ma_lat));
            if (!cur_st) sb_pop(1'b1, ma_rdata);
            ma_re = 1'b0; ma_we = 1'b0;
            pend--;
         end
         if (if_done === 1'b1) begin
            check_eq("if_lat", 32'(cyc), 32'(if_lat));
            sb_pop(1'b0, if_rdata);
            if_req = 1'b0;
            pend--;
         end
         if (frz_len > 0 && cyc == frz_at) rdy = 1'b0;
         if (frz_len > 0 && cyc == frz_at + frz_len) rdy = 1'b1;
      end
      if (pend > 0) check_eq("timeout", 32'(pend), 32'd0);
      rdy = 1'b1;
   endtask

   task automatic chk_store(input logic [31:0] a, input logic [31:0] d, input int n, input int wr0);
      check_eq("st_wrcnt", 32'(wr_cnt - wr0), 32'(n));
      for (int k = 0; k < n; k++) check_eq("st_byte", 32'(mem_rd(a + 32'(k))), 32'(d[8*k +: 8]));
   endtask

   initial begin
      int          wr0;
      logic        seen;
      total_cnt = 0; bad_cnt = 0; cur_st = 1'b0;
      rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      ma_re = 1'b0; ma_we = 1'b0; ma_width = 3'b000; ma_addr = 32'h0; ma_wdata = 32'h0;
      repeat (3) tick();

      // reset state
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
      check_eq("rst_if_done", 32'(if_done), 32'd0);
      check_eq("rst_ma_done", 32'(ma_done), 32'd0);
      check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst_mem_a", mem_a, 32'h0);
      check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
      check_eq("rst_if_rdata", if_rdata, 32'h0);
      check_eq("rst_ma_rdata", ma_rdata, 32'h0);
      rst = 1'b0;
      tick();

      // fetch word 0x1000
      init_ram[32'h1000] = 8'h11; init_ram[32'h1001] = 8'h22;
      init_ram[32'h1002] = 8'h33; init_ram[32'h1003] = 8'h44;
      check_eq("if_model", exp_load(3'b010, 32'h1000), 32'h44332211);
      drv_if(32'h1000);
      run_wait(0, 6, 0, 0);
      tick();

      // SW 0xDEADBEEF at 0x2000
      wr0 = wr_cnt;
      drv_ma(1'b1, 3'b010, 32'h2000, 32'hDEADBEEF);
      run_wait(5, 0, 0, 0);
      chk_store(32'h2000, 32'hDEADBEEF, 4, wr0);
      check_eq("sw_mem_a_hold", mem_a, 32'h2003);
      check_eq("sw_dout_idle", 32'(mem_dout), 32'd0);
      tick();

      // LB / LBU of 0x80
      init_ram[32'h3000] = 8'h80;
      drv_ma(1'b0, 3'b000, 32'h3000, 32'h0);
      run_wait(3, 0, 0, 0);
      tick();
      drv_ma(1'b0, 3'b100, 32'h3000, 32'h0);
      run_wait(3, 0, 0, 0);
      tick();

      // IF and LH collide: MA first, IF from the next IDLE
      preload(32'h4000, 2);
      preload(32'h4100, 4);
      drv_ma(1'b0, 3'b001, 32'h4000, 32'h0);
      drv_if(32'h4100);
      run_wait(4, 11, 0, 0);
      tick();

      // LW across the top of the address space, reserved width code
      preload(32'hFFFF_FFFE, 2);
      preload(32'h0000_0000, 2);
      drv_ma(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
      run_wait(6, 0, 0, 0);
      tick();
      preload(32'h6000, 4);
      drv_ma(1'b0, 3'b011, 32'h6000, 32'h0);
      run_wait(6, 0, 0, 0);
      tick();

      // randomized loads and stores
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  w;
         logic [31:0] a;
         logic [31:0] d;
         int          n;
         logic        st;
         case ($urandom_range(0, 5))
            0:       w = 3'b000;
            1:       w = 3'b001;
            2:       w = 3'b010;
            3:       w = 3'b100;
            4:       w = 3'b101;
            default: w = 3'b110;
         endcase
         a  = 32'h0010_0000 + 32'(i) * 32'h100 + 32'($urandom_range(0, 250));
         d  = $urandom;
         n  = (w == 3'b000 || w == 3'b100) ? 1 : ((w == 3'b001 || w == 3'b101) ? 2 : 4);
         st = (w == 3'b000 || w == 3'b001 || w == 3'b010) && ($urandom_range(0, 1) == 1);
         if (st) begin
            wr0 = wr_cnt;
            drv_ma(1'b1, w, a, d);
            run_wait(n + 1, 0, 0, 0);
            chk_store(a, d, n, wr0);
         end else begin
            preload(a, 4);
            drv_ma(1'b0, w, a, 32'h0);
            run_wait(n + 2, 0, 0, 0);
         end
         tick();
      end

      // rdy low for 3 cycles in the middle of SW and LW
      wr0 = wr_cnt;
      drv_ma(1'b1, 3'b010, 32'h7000, 32'hA1B2C3D4);
      run_wait(8, 0, 2, 3);
      chk_store(32'h7000, 32'hA1B2C3D4, 4, wr0);
      tick();
      preload(32'h7100, 4);
      drv_ma(1'b0, 3'b010, 32'h7100, 32'h0);
      run_wait(9, 0, 2, 3);
      tick();

      // reset in the second XFER cycle of a store
      wr0 = wr_cnt;
      drv_ma(1'b1, 3'b010, 32'h5000, 32'h11223344);
      tick();
      tick();
      rst = 1'b1; ma_we = 1'b0; ma_re = 1'b0;
      tick();
      rst = 1'b0;
      check_eq("rst_mid_state", 32'(dbg_state), 32'(IDLE));
      seen = 1'b0;
      repeat (8) begin
         tick();
         if (ma_done === 1'b1 || mem_wr === 1'b1) seen = 1'b1;
      end
      check_eq("rst_mid_quiet", 32'(seen), 32'd0);
      check_eq("rst_mid_wrcnt", 32'(wr_cnt - wr0), 32'd2);
      check_eq("rst_mid_b1", 32'(mem_rd(32'h5001)), 32'h33);
      check_eq("rst_mid_b2", 32'(mem_rd(32'h5002)), 32'h00);

      check_eq("sb_left", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; low freezes all state, mem_wr forced 0.
REQ-004 if_req  in  1  fetch read request, held high until if_done.
REQ-005 if_addr  in  32  fetch byte address, always a 4-byte read.
REQ-006 if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid that cycle.
REQ-007 if_rdata  out  32  fetched word, little-endian.
REQ-008 ma_re / ma_we  in  1 each  data load/store request, held until ma_done; both high means store.
REQ-009 ma_width  in  3  RISC-V funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 ma_addr  in  32  data byte address.
REQ-011 ma_wdata  in  32  store data; low 1/2/4 bytes used.
REQ-012 ma_done  out  1  one-cycle pulse: data access complete.
REQ-013 ma_rdata  out  32  load result, sign/zero-extended per ma_width.
REQ-014 mem_a  out  32  RAM byte address.
REQ-015 mem_wr  out  1  RAM write strobe for the current byte.
REQ-016 mem_dout  out  8  RAM write byte.
REQ-017 mem_din  in  8  RAM read byte, valid one cycle after its address.

Function
REQ-018 States: IDLE, XFER, LAST, DONE; single outstanding transaction.
REQ-019 IDLE: sample requests; MA wins over IF when both high (fixed priority); latch owner, address, byte count N (1/2/4), data, width; go XFER.
REQ-020 Unused/reserved ma_width codes: treated as N=4.
REQ-021 XFER: cycle k (k=0..N-1) drives mem_a=base+k; stores drive mem_wr=1, mem_dout=byte k.
REQ-022 Reads capture mem_din into byte k-1 each XFER cycle k>=1, final byte in LAST.
REQ-023 After byte N-1: reads go LAST then DONE; writes go DONE directly.
REQ-024 Latency from sampling edge: read done in cycle N+2, write done in cycle N+1 (LW=6, SW=5, LB=3, SB=2).
REQ-025 DONE: pulse owner's done; rdata valid only that cycle; next state IDLE.
REQ-026 Requester drops req at the edge ending DONE; IDLE re-samples, no extra bubble.
REQ-027 Address arithmetic wraps modulo 2^32; no alignment check.
REQ-028 Outside XFER: mem_wr=0, mem_a holds last value, mem_dout=0.
REQ-029 Request deasserted mid-transaction: ignored, transaction completes.

Reset
REQ-030 rst: state IDLE; if_done, ma_done, mem_wr=0; mem_a, mem_dout, if_rdata, ma_rdata=0; priority pointer to MA.
REQ-031 rst mid-transaction aborts it: no done pulse; no further mem_wr.
REQ-032 rst has priority over rdy.

Configuration
REQ-033 MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the owner not served last wins; pointer updates at DONE.
REQ-034 MEM_ARB_RR_EN undefined: fixed MA-over-IF priority per REQ-019; no pointer register.

Structure
REQ-035 State encodings, ma_width codes and byte-count constants live in the shared defines header.
REQ-036 One sub-module, mem_load_ext: combinational byte assembly plus sign/zero extension for ma_rdata.

Verification
REQ-037 IF read 0x1000, RAM bytes 11,22,33,44 -> if_done cycle 6, if_rdata=0x44332211.
REQ-038 MA SW 0x2000 data 0xDEADBEEF -> mem_wr four cycles, bytes EF,BE,AD,DE at 0x2000..3, ma_done cycle 5.
REQ-039 LB / LBU 0x3000, byte 0x80 -> ma_rdata 0xFFFFFF80 / 0x00000080 at cycle 3.
REQ-040 IF and MA (LH) requested same cycle -> MA served first, IF follows from next IDLE; with MEM_ARB_RR_EN, second collision serves IF first.
REQ-041 rst high in XFER cycle 2 of SW -> no more mem_wr, no ma_done, state IDLE.
REQ-042 rdy low 3 cycles mid-LW -> result unchanged, done delayed exactly 3 cycles, mem_wr=0 while frozen.
